// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges structural and control hazards into
// per-stage hold/bubble buses and owns the redirect handshake to the fetch unit.
module pipe_hazard_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ifu_busy_i,
    input  logic             load_use_i,
    input  logic             muldiv_busy_i,
    input  logic             lsu_busy_i,
    input  logic             branch_valid_i,
    input  logic [XLEN-1:0]  branch_pc_i,
    input  logic             trap_valid_i,
    input  logic [XLEN-1:0]  trap_pc_i,
    input  logic             redirect_ready_i,
    output logic [5:0]       stall_valid_o,
    output logic [5:0]       flush_valid_o,
    output logic             redirect_valid_o,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             dbg_state_o
);

    localparam int CTRLBUS_PC = 0;

    localparam logic [5:0] LSU_STALL  = 6'h0F;
    localparam logic [5:0] LSU_FLUSH  = 6'h10;
    localparam logic [5:0] TRAP_FLUSH = 6'h0E;
    localparam logic [5:0] MD_STALL   = 6'h07;
    localparam logic [5:0] MD_FLUSH   = 6'h08;
    localparam logic [5:0] BR_FLUSH   = 6'h06;
    localparam logic [5:0] LU_STALL   = 6'h03;
    localparam logic [5:0] LU_FLUSH   = 6'h04;
    localparam logic [5:0] IFU_STALL  = 6'h01;
    localparam logic [5:0] IFU_FLUSH  = 6'h02;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_REDIR = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pend_pc;
    logic [XLEN-1:0]   w_pend_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [5:0]        w_stall;
    logic [5:0]        w_flush;
    logic              w_redir_valid;
    logic [XLEN-1:0]   w_redir_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_pend_pc   <= '0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_next_state;
            r_pend_pc <= w_pend_next;
            if (stall_valid_o[CTRLBUS_PC] && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_pend_next   = r_pend_pc;
        w_stall       = '0;
        w_flush       = '0;
        w_redir_valid = 1'b0;
        w_redir_pc    = '0;
        case (r_state)
            S_RUN: begin
                if (lsu_busy_i) begin
                    w_stall = LSU_STALL;
                    w_flush = LSU_FLUSH;
                end else if (trap_valid_i) begin
                    w_flush       = TRAP_FLUSH;
                    w_redir_valid = 1'b1;
                    w_redir_pc    = trap_pc_i;
                    if (!redirect_ready_i) begin
                        w_pend_next  = trap_pc_i;
                        w_next_state = S_REDIR;
                    end
                end else if (muldiv_busy_i) begin
                    w_stall = MD_STALL;
                    w_flush = MD_FLUSH;
                end else if (branch_valid_i) begin
                    w_flush       = BR_FLUSH;
                    w_redir_valid = 1'b1;
                    w_redir_pc    = branch_pc_i;
                    if (!redirect_ready_i) begin
                        w_pend_next  = branch_pc_i;
                        w_next_state = S_REDIR;
                    end
                end else if (load_use_i) begin
                    w_stall = LU_STALL;
                    w_flush = LU_FLUSH;
                end else if (ifu_busy_i) begin
                    w_stall = IFU_STALL;
                    w_flush = IFU_FLUSH;
                end
            end
            S_REDIR: begin
                w_redir_valid = 1'b1;
                w_redir_pc    = r_pend_pc;
                w_stall       = IFU_STALL;
                w_flush       = IFU_FLUSH;
                if (lsu_busy_i) begin
                    w_stall = w_stall | LSU_STALL;
                    w_flush = w_flush | LSU_FLUSH;
                end
                // A new trap replaces the target; the old one may be accepted this
                // cycle, so stay here until the trap target itself is handed over.
                if (trap_valid_i)
                    w_pend_next = trap_pc_i;
                else if (redirect_ready_i)
                    w_next_state = S_RUN;
            end
            default: w_next_state = S_RUN;
        endcase
    end

    // Held stages must keep their contents, so a hold always wins over a bubble.
    always_comb begin
        stall_valid_o    = '0;
        flush_valid_o    = '0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        if (!rst) begin
            stall_valid_o    = {1'b0, w_stall[4:0]};
            flush_valid_o    = {1'b0, w_flush[4:0] & ~w_stall[4:0]};
            redirect_valid_o = w_redir_valid;
            redirect_pc_o    = w_redir_pc;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: priority table in RUN plus hand-written redirect,
// trap-override, counter saturation and async-reset sequences.
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 64;
  localparam int CNT_W = 4;
  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_REDIR = 1'b1;

  logic             clk = 1'b0;
  logic             rst;
  logic             ifu_busy, load_use, muldiv_busy, lsu_busy;
  logic             branch_valid, trap_valid, redirect_ready;
  logic [XLEN-1:0]  branch_pc, trap_pc;
  logic [5:0]       stall_valid, flush_valid;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic             dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] exp_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .ifu_busy_i       (ifu_busy),
    .load_use_i       (load_use),
    .muldiv_busy_i    (muldiv_busy),
    .lsu_busy_i       (lsu_busy),
    .branch_valid_i   (branch_valid),
    .branch_pc_i      (branch_pc),
    .trap_valid_i     (trap_valid),
    .trap_pc_i        (trap_pc),
    .redirect_ready_i (redirect_ready),
    .stall_valid_o    (stall_valid),
    .flush_valid_o    (flush_valid),
    .redirect_valid_o (redirect_valid),
    .redirect_pc_o    (redirect_pc),
    .stall_cnt_o      (stall_cnt),
    .dbg_state_o      (dbg_state)
  );

  typedef struct {
    logic       lsu, trap, md, br, lu, ifu;
    logic [5:0] es, ef;
    logic       erv;
    logic [63:0] erpc;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lsu, input logic trap, input logic md, input logic br,
                       input logic lu, input logic ifu, input logic rdy,
                       input logic [63:0] bpc, input logic [63:0] tpc);
    lsu_busy = lsu; trap_valid = trap; muldiv_busy = md; branch_valid = br;
    load_use = lu; ifu_busy = ifu; redirect_ready = rdy;
    branch_pc = bpc; trap_pc = tpc;
  endtask

  task automatic idle(input logic rdy);
    drive(0, 0, 0, 0, 0, 0, rdy, 64'h0, 64'h0);
  endtask

  // One cycle: check comb outputs mid-cycle, then advance the counter model at the edge.
  task automatic cyc(input string name, input logic est, input logic [5:0] es,
                     input logic [5:0] ef, input logic erv, input logic [63:0] erpc);
    @(negedge clk);
    chk({name, " state"}, 64'(dbg_state), 64'(est));
    chk({name, " stall"}, 64'(stall_valid), 64'(es));
    chk({name, " flush"}, 64'(flush_valid), 64'(ef));
    chk({name, " rvalid"}, 64'(redirect_valid), 64'(erv));
    chk({name, " rpc"}, redirect_pc, erpc);
    chk({name, " cnt"}, 64'(stall_cnt), 64'(exp_cnt));
    @(posedge clk);
    if (es[0] && exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 1, 1, 1, 64'h0, 64'h0);
    exp_cnt = '0;
    @(negedge clk);
    chk("reset stall", 64'(stall_valid), 64'h0);
    chk("reset flush", 64'(flush_valid), 64'h0);
    chk("reset rvalid", 64'(redirect_valid), 64'h0);
    chk("reset cnt", 64'(stall_cnt), 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);
  endtask

  initial begin
    rst = 1'b1;
    idle(1);
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Priority table in RUN, redirect always accepted immediately.
    vecs[0]  = '{0,0,0,0,0,0, 6'h00, 6'h00, 0, 64'h0};
    vecs[1]  = '{0,0,0,0,0,1, 6'h01, 6'h02, 0, 64'h0};
    vecs[2]  = '{0,0,0,0,1,0, 6'h03, 6'h04, 0, 64'h0};
    vecs[3]  = '{0,0,0,0,1,1, 6'h03, 6'h04, 0, 64'h0};
    vecs[4]  = '{0,0,0,1,0,0, 6'h00, 6'h06, 1, 64'h8000_0100};
    vecs[5]  = '{0,0,0,1,1,1, 6'h00, 6'h06, 1, 64'h8000_0100};
    vecs[6]  = '{0,0,1,0,0,0, 6'h07, 6'h08, 0, 64'h0};
    vecs[7]  = '{0,0,1,1,0,0, 6'h07, 6'h08, 0, 64'h0};
    vecs[8]  = '{0,1,0,0,0,0, 6'h00, 6'h0E, 1, 64'h8000_0004};
    vecs[9]  = '{0,1,1,1,1,1, 6'h00, 6'h0E, 1, 64'h8000_0004};
    vecs[10] = '{1,0,0,0,0,0, 6'h0F, 6'h10, 0, 64'h0};
    vecs[11] = '{1,1,1,1,1,1, 6'h0F, 6'h10, 0, 64'h0};
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].lsu, vecs[i].trap, vecs[i].md, vecs[i].br, vecs[i].lu, vecs[i].ifu, 1,
            64'h8000_0100, 64'h8000_0004);
      cyc($sformatf("vec%0d", i), ST_RUN, vecs[i].es, vecs[i].ef, vecs[i].erv, vecs[i].erpc);
    end

    // Single load-use cycle after a fresh reset.
    do_reset();
    drive(0, 0, 0, 0, 1, 0, 1, 64'h0, 64'h0);
    cyc("lu", ST_RUN, 6'h03, 6'h04, 0, 64'h0);
    idle(1);
    cyc("lu_after", ST_RUN, 6'h00, 6'h00, 0, 64'h0);
    chk("lu_cnt_one", 64'(stall_cnt), 64'h1);

    // Branch accepted in the same cycle.
    drive(0, 0, 0, 1, 0, 0, 1, 64'h8000_0100, 64'h0);
    cyc("br_ready", ST_RUN, 6'h00, 6'h06, 1, 64'h8000_0100);
    idle(1);
    cyc("br_ready_after", ST_RUN, 6'h00, 6'h00, 0, 64'h0);

    // Branch held off by the IFU for three cycles.
    drive(0, 0, 0, 1, 0, 0, 0, 64'h8000_0200, 64'h0);
    cyc("br_wait0", ST_RUN, 6'h00, 6'h06, 1, 64'h8000_0200);
    idle(0);
    cyc("br_wait1", ST_REDIR, 6'h01, 6'h02, 1, 64'h8000_0200);
    cyc("br_wait2", ST_REDIR, 6'h01, 6'h02, 1, 64'h8000_0200);
    idle(1);
    cyc("br_wait3", ST_REDIR, 6'h01, 6'h02, 1, 64'h8000_0200);
    cyc("br_wait_done", ST_RUN, 6'h00, 6'h00, 0, 64'h0);

    // LSU busy masks a trap; the trap wins once memory returns.
    drive(1, 1, 0, 0, 0, 0, 1, 64'h0, 64'h8000_0004);
    cyc("lsu_trap", ST_RUN, 6'h0F, 6'h10, 0, 64'h0);
    drive(0, 1, 0, 0, 0, 0, 1, 64'h0, 64'h8000_0004);
    cyc("trap_after_lsu", ST_RUN, 6'h00, 6'h0E, 1, 64'h8000_0004);

    // Trap overrides a pending branch redirect; LSU stall merges into REDIR.
    drive(0, 0, 0, 1, 0, 0, 0, 64'h8000_0200, 64'h0);
    cyc("pend_br", ST_RUN, 6'h00, 6'h06, 1, 64'h8000_0200);
    drive(1, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
    cyc("redir_lsu", ST_REDIR, 6'h0F, 6'h10, 1, 64'h8000_0200);
    drive(0, 1, 0, 0, 0, 0, 0, 64'h0, 64'h8000_0004);
    cyc("redir_trap", ST_REDIR, 6'h01, 6'h02, 1, 64'h8000_0200);
    drive(0, 0, 0, 1, 0, 0, 0, 64'h8000_0300, 64'h0);
    cyc("redir_newpc", ST_REDIR, 6'h01, 6'h02, 1, 64'h8000_0004);
    idle(1);
    cyc("redir_accept", ST_REDIR, 6'h01, 6'h02, 1, 64'h8000_0004);
    cyc("redir_back", ST_RUN, 6'h00, 6'h00, 0, 64'h0);

    // Counter saturates at all-ones.
    do_reset();
    drive(0, 0, 0, 0, 0, 1, 1, 64'h0, 64'h0);
    for (int i = 0; i < 20; i++) cyc($sformatf("sat%0d", i), ST_RUN, 6'h01, 6'h02, 0, 64'h0);
    chk("sat_final", 64'(stall_cnt), 64'hF);

    // Asynchronous reset in the middle of a pending redirect.
    drive(0, 0, 0, 1, 0, 0, 0, 64'h8000_0200, 64'h0);
    cyc("pre_rst_br", ST_RUN, 6'h00, 6'h06, 1, 64'h8000_0200);
    idle(0);
    #2;
    chk("pre_rst_state", 64'(dbg_state), 64'(ST_REDIR));
    rst = 1'b1;
    exp_cnt = '0;
    #1;
    chk("rst_async_stall", 64'(stall_valid), 64'h0);
    chk("rst_async_flush", 64'(flush_valid), 64'h0);
    chk("rst_async_rvalid", 64'(redirect_valid), 64'h0);
    chk("rst_async_rpc", redirect_pc, 64'h0);
    chk("rst_async_cnt", 64'(stall_cnt), 64'h0);
    chk("rst_async_state", 64'(dbg_state), 64'(ST_RUN));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("post_rst", ST_RUN, 6'h00, 6'h00, 0, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
